imem_prefetch: RTL and testbench
================================

IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction buffer entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port halt  in  1  freezes request issue and output presentation.
REQ-006 SHALL have port redirect_valid  in  1  jump/branch taken; flush and refetch.
REQ-007 SHALL have port redirect_pc  in  32  new fetch address.
REQ-008 SHALL have port mem_req  out  1  instruction memory read request.
REQ-009 SHALL have port mem_addr  out  32  request address, word aligned.
REQ-010 SHALL have port mem_gnt  in  1  request accepted this cycle.
REQ-011 SHALL have port mem_rvalid  in  1  read data valid; responses return in request order, latency >= 1.
REQ-012 SHALL have port mem_rdata  in  32  instruction word.
REQ-013 SHALL have port inst_valid  out  1  buffered instruction available to the fetch stage.
REQ-014 SHALL have port inst_data  out  32  head instruction.
REQ-015 SHALL have port inst_pc  out  32  address of head instruction.
REQ-016 SHALL have port inst_ready  in  1  fetch stage consumes head this cycle.
REQ-017 SHALL have port level  out  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-018 SHALL hold fetch_pc; on each accepted request (mem_req & mem_gnt) fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 SHALL drive mem_addr = fetch_pc, bits [1:0] always 0.
REQ-020 SHALL assert mem_req only when level + outstanding < DEPTH, halt = 0, redirect_valid = 0.
REQ-021 SHALL, once mem_req is raised, hold it and mem_addr stable until mem_gnt, except when dropped by halt or redirect.
REQ-022 SHALL count outstanding requests (granted, response pending), range 0..DEPTH; +1 on grant, -1 on rvalid, unchanged on both.
REQ-023 SHALL, on mem_rvalid with drop_cnt = 0, push {mem_rdata, pc} into the FIFO; pc taken from a response-pc counter advancing by 4 per push.
REQ-024 SHALL present pushed data at inst_valid/inst_data/inst_pc exactly 1 cycle after the mem_rvalid cycle; no combinational bypass.
REQ-025 SHALL pop head when inst_valid & inst_ready; simultaneous push and pop leave level unchanged.
REQ-026 SHALL drive inst_valid = 0 when empty or halt = 1; inst_data/inst_pc hold head contents regardless.
REQ-027 SHALL, on redirect_valid: empty the FIFO (level 0 next cycle), set fetch_pc and response-pc to {redirect_pc[31:2],2'b00}, deassert mem_req that cycle.
REQ-028 SHALL set drop_cnt = outstanding - mem_rvalid on redirect; discard that cycle's response and the next drop_cnt responses without pushing.
REQ-029 SHALL decrement drop_cnt on each discarded rvalid; a second redirect while drop_cnt > 0 recomputes drop_cnt from current outstanding.
REQ-030 SHALL ignore inst_ready in a redirect cycle (no pop counted).
REQ-031 SHALL, under halt, still accept responses for outstanding requests (push or drop) but issue no new request.
REQ-032 SHALL never push when full; credit rule REQ-020 guarantees this; rvalid with outstanding = 0 is a protocol error, ignored.

Reset
REQ-033 SHALL on rst_n = 0 immediately set mem_req 0, inst_valid 0, level 0, outstanding 0, drop_cnt 0, fetch_pc and response-pc RESET_PC, mem_addr RESET_PC.
REQ-034 SHALL raise mem_req with mem_addr = RESET_PC in the first cycle after reset release (halt = 0); reset mid-transfer discards all in-flight state.

Verification
REQ-035 Streaming: gnt=1 always, rvalid 1 cycle after grant, ready=1 -> inst_pc 0,4,8,... one per cycle, level <= 2.
REQ-036 Backpressure: ready=0, DEPTH=4 -> exactly 4 grants (0..C), mem_req 0 thereafter, level 4; ready=1 one cycle -> one new request at 0x10.
REQ-037 Redirect with 3 outstanding, latency 3, redirect_pc 0x103 -> 3 responses dropped, first inst_pc 0x100, level 0 at redirect+1.
REQ-038 Redirect coincident with rvalid and inst_ready, 2 outstanding -> drop_cnt 1, no pop, no push, next fetch 0x200.
REQ-039 Wrap: redirect_pc 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 Async reset asserted mid-stream with 2 outstanding -> outputs cleared same cycle; post-release first mem_addr RESET_PC, stale rvalids ignored.

Source files
------------

// File: rtl/imem_prefetch.sv
// Instruction prefetch buffer: issues sequential word fetches under a credit limit,
// queues returning instructions with their PCs, and flushes/refetches on redirect.
module imem_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW:0]   DEPTH_WIDE = (LW + 1)'(DEPTH);
  localparam logic [LW-1:0] DEPTH_LVL  = LW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [LW-1:0] outstanding;
  logic [LW-1:0] drop_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] buf_data [DEPTH];
  logic [31:0] buf_pc   [DEPTH];

  logic [31:0] target_pc;
  logic        credit_ok;
  logic        gnt_fire;
  logic        rsp_fire;
  logic        dropping;
  logic        push;
  logic        pop;

  assign target_pc = redirect_pc & ~32'h3;

  // Every granted request reserves a buffer slot, so level + outstanding can never exceed DEPTH.
  assign credit_ok = ({1'b0, level} + {1'b0, outstanding}) < DEPTH_WIDE;
  assign mem_req   = rst_n && credit_ok && !halt && !redirect_valid;
  assign mem_addr  = fetch_pc;
  assign gnt_fire  = mem_req && mem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire  = mem_rvalid && (outstanding != '0);
  assign dropping  = redirect_valid || (drop_cnt != '0);
  assign push      = rsp_fire && !dropping && (level != DEPTH_LVL);

  assign inst_valid = (level != '0) && !halt;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_data  = buf_data[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + LW'(gnt_fire) - LW'(rsp_fire);

      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // Everything still in flight after this cycle belongs to the abandoned path.
        drop_cnt <= outstanding - LW'(rsp_fire);
        level    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (gnt_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (rsp_fire && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - LW'(1);
        end
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

  // NOTE: buffer storage has no reset; entries are only read when level marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_imem_prefetch.sv
// Randomized bench for imem_prefetch: a memory responder, an in-order fetch-stream
// scoreboard and a per-cycle occupancy/credit model.
module tb_imem_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic              clk;
  logic              rst_n;
  logic              halt;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [31:0]       inst_pc;
  logic              inst_ready;
  logic [$clog2(DEPTH):0] level;

  imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
    bit          orphan;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          gnt_pct = 100;
  int          lat_lo  = 1;
  int          lat_hi  = 1;
  bit          mem_block = 1'b0;

  logic [31:0] mpc = RESET_PC;
  int          lvl = 0;
  int          gnt_cnt = 0;
  int          pop_cnt = 0;
  int          max_level = 0;
  logic [31:0] last_gnt_addr = '0;
  bit          want_first = 1'b0;
  logic [31:0] first_pop_pc = '0;
  logic [31:0] prev_pop_pc = '0;
  bit          wrap_seen = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory responder: grants at random, answers in order after the latency drawn at grant.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rst_n) begin
        if (mem_req && !mem_block && ($urandom_range(99) < gnt_pct)) mem_gnt = 1'b1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word_at(pend[0].addr);
        end
      end
    end
  end

  // Monitor: the fetch stream since the last redirect/reset must be consecutive words from
  // its start address; occupancy follows from useful responses minus consumed instructions.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        foreach (pend[i]) pend[i].orphan = 1'b1;
        exp_q.delete();
        mpc = RESET_PC;
        lvl = 0;
      end else begin
        int          live;
        int          nl;
        bit          exp_req;
        bit          exp_valid;
        bit          redir;
        bit          pop;
        pend_t       e;
        logic [31:0] epc;
        live = 0;
        foreach (pend[i]) if (!pend[i].orphan) live++;
        redir     = redirect_valid;
        exp_req   = !halt && !redir && (lvl + live < DEPTH);
        exp_valid = (lvl > 0) && !halt;
        check("mem_req", mem_req, exp_req);
        if (mem_req) check("mem_addr", mem_addr, mpc);
        check("level", level, lvl);
        check("inst_valid", inst_valid, exp_valid);
        if (int'(level) > max_level) max_level = int'(level);

        nl = lvl;
        if (redir) begin
          foreach (pend[i]) pend[i].stale = 1'b1;
          exp_q.delete();
        end
        if (mem_rvalid && pend.size() != 0) begin
          e = pend.pop_front();
          if (!e.stale && !e.orphan) nl++;
        end
        pop = exp_valid && inst_ready && !redir;
        if (pop) begin
          if (exp_q.size() == 0) begin
            check("pop_without_fetch", 32'd1, 32'd0);
          end else begin
            epc = exp_q.pop_front();
            check("inst_pc", inst_pc, epc);
            check("inst_data", inst_data, word_at(epc));
            if (want_first) begin
              first_pop_pc = epc;
              want_first   = 1'b0;
            end
            if (prev_pop_pc == 32'hFFFF_FFFC && epc == 32'h0) wrap_seen = 1'b1;
            prev_pop_pc = epc;
          end
          pop_cnt++;
          nl--;
        end
        if (redir) begin
          nl  = 0;
          mpc = redirect_pc & ~32'h3;
        end
        if (mem_req && mem_gnt) begin
          e.addr   = mem_addr;
          e.due    = cyc + $urandom_range(lat_hi, lat_lo);
          e.stale  = 1'b0;
          e.orphan = 1'b0;
          pend.push_back(e);
          exp_q.push_back(mpc);
          last_gnt_addr = mem_addr;
          mpc = mpc + 32'd4;
          gnt_cnt++;
        end
        lvl = nl;
      end
      cyc++;
    end
  end

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_inst_valid", inst_valid, 1'b0);
    check("reset_level", level, '0);
    check("reset_mem_addr", mem_addr, RESET_PC);
    @(negedge clk);

    // Streaming from reset: one instruction per cycle, shallow occupancy.
    inst_ready = 1'b1; want_first = 1'b1; pop_cnt = 0; max_level = 0;
    rst_n = 1'b1;
    #2;
    check("first_req_after_reset", mem_req, 1'b1);
    check("first_addr_after_reset", mem_addr, RESET_PC);
    repeat (40) @(negedge clk);
    #2;
    check("stream_pop_count_ok", pop_cnt >= 35, 1'b1);
    check("stream_level_le_2", max_level <= 2, 1'b1);
    check("stream_first_pc", first_pop_pc, RESET_PC);
    @(negedge clk);

    // Backpressure: exactly DEPTH grants then no requests; one pop frees one credit.
    inst_ready = 1'b0; gnt_cnt = 0;
    redirect_to(32'h0);
    repeat (30) @(negedge clk);
    #2;
    check("bp_grants", gnt_cnt, 4);
    check("bp_level_full", level, 4);
    check("bp_req_low", mem_req, 1'b0);
    check("bp_last_addr", last_gnt_addr, 32'hC);
    @(negedge clk);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("bp_refill_grants", gnt_cnt, 5);
    check("bp_refill_addr", last_gnt_addr, 32'h10);
    @(negedge clk);

    // Redirect with several long-latency requests in flight, unaligned target.
    inst_ready = 1'b1; lat_lo = 3; lat_hi = 3;
    repeat (12) @(negedge clk);
    want_first = 1'b1;
    redirect_to(32'h103);
    #2;
    check("redirect_level_zero", level, '0);
    @(negedge clk);
    repeat (15) @(negedge clk);
    #2;
    check("redirect_first_pc", first_pop_pc, 32'h100);
    @(negedge clk);

    // Address wrap at the top of memory.
    lat_lo = 1; lat_hi = 1; wrap_seen = 1'b0; want_first = 1'b1;
    redirect_to(32'hFFFF_FFF8);
    repeat (10) @(negedge clk);
    #2;
    check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
    check("wrap_seen", wrap_seen, 1'b1);
    @(negedge clk);

    // Random traffic: halts, redirects (some near the wrap point), stalls, variable latency.
    gnt_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      halt           = ($urandom_range(9) == 0);
      redirect_valid = ($urandom_range(24) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                                                : $urandom();
      inst_ready     = ($urandom_range(9) < 7);
      @(negedge clk);
    end
    halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;

    // Asynchronous reset mid-stream; stale responses must be ignored afterwards.
    gnt_pct = 100; lat_lo = 2; lat_hi = 2;
    repeat (10) @(negedge clk);
    mem_block = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 1'b0);
    check("async_rst_inst_valid", inst_valid, 1'b0);
    check("async_rst_level", level, '0);
    check("async_rst_mem_addr", mem_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_release_req", mem_req, 1'b1);
    check("rst_release_addr", mem_addr, RESET_PC);
    for (int k = 0; k < 20 && pend.size() != 0; k++) @(negedge clk);
    #2;
    check("stale_responses_drained", pend.size(), 0);
    check("stale_level", level, '0);
    @(negedge clk);
    mem_block = 1'b0; want_first = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("post_reset_first_pc", first_pop_pc, RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
